// File: rtl/oled_frame_streamer.sv
// oled_frame_streamer
//   Walks pixel_index over a WIDTH x HEIGHT panel once per frame and samples the
//   RGB565 colour returned for each index. For each frame it sends a 6-byte
//   address-window preamble, then streams every pixel MSB-first over 4-wire SPI
//   (mode 3) to a PmodOLEDrgb. Between frames the link idles for GAP_CYCLES
//   cycles.
//
// Ports
//   clk6p25m       in   single clock for all logic
//   reset          in   asynchronous, active-high
//   pixel_data     in   RGB565 colour for pixel_index, latched when sample_pixel is high
//   pixel_index    out  requested index y*WIDTH+x (one pixel ahead of the bits on the wire)
//   frame_begin    out  1-cycle pulse on the first command cycle of a frame
//   sending_pixels out  high while pixel bits are being shifted
//   sample_pixel   out  1-cycle strobe; pixel_data is captured at the end of that cycle
//   cs_n/sclk/mosi/dc out  SPI link, sclk idles high, dc=1 for pixel data
//
// WIDTH*HEIGHT must not exceed 8192; GAP_CYCLES must be at least 1.
module oled_frame_streamer #(
  parameter int unsigned WIDTH      = 96,
  parameter int unsigned HEIGHT     = 64,
  parameter int unsigned GAP_CYCLES = 1000
) (
  input  logic        clk6p25m,
  input  logic        reset,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        frame_begin,
  output logic        sending_pixels,
  output logic        sample_pixel,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  output logic        dc
);

  localparam int unsigned NumPix  = WIDTH * HEIGHT;
  localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [12:0]     PixLast = 13'(NumPix - 1);
  localparam logic [47:0]     CmdWord = {8'h15, 8'h00, 8'(WIDTH - 1),
                                         8'h75, 8'h00, 8'(HEIGHT - 1)};

  typedef enum logic [1:0] {StGap, StCmd, StPixel} state_e;

  state_e          state_q, state_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [6:0]      cnt_q, cnt_d;   // cycle within preamble (0..95) or pixel slot (0..31)
  logic [12:0]     pix_q, pix_d;   // pixel currently on the wire
  logic [15:0]     word_q, word_d; // colour of the pixel on the wire

  logic [12:0] pixel_index_d;
  logic        frame_begin_d, sending_pixels_d, sample_pixel_d;
  logic        cs_n_d, sclk_d, mosi_d, dc_d;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    // sample_pixel is the registered strobe, so it marks the current cycle as the sample cycle.
    word_d  = sample_pixel ? pixel_data : word_q;

    frame_begin_d = 1'b0;

    unique case (state_q)
      StGap: begin
        if (gap_q == GapLast) begin
          state_d       = StCmd;
          gap_d         = '0;
          cnt_d         = '0;
          frame_begin_d = 1'b1;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StCmd: begin
        if (cnt_q == 7'd95) begin
          state_d = StPixel;
          cnt_d   = '0;
          pix_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StPixel: begin
        if (cnt_q == 7'd31) begin
          cnt_d = '0;
          if (pix_q == PixLast) begin
            state_d = StGap;
            gap_d   = '0;
            pix_d   = '0;
          end else begin
            pix_d = pix_q + 13'd1;
          end
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      default: state_d = StGap;
    endcase

    // Outputs are derived from the next state so that every output is a plain register.
    pixel_index_d    = '0;
    sending_pixels_d = 1'b0;
    sample_pixel_d   = 1'b0;
    cs_n_d           = 1'b1;
    sclk_d           = 1'b1;
    mosi_d           = 1'b0;
    dc_d             = 1'b0;

    case (state_d)
      StCmd: begin
        cs_n_d         = 1'b0;
        sclk_d         = cnt_d[0];
        mosi_d         = CmdWord[6'd47 - cnt_d[6:1]];
        sample_pixel_d = (cnt_d == 7'd95);
      end
      StPixel: begin
        cs_n_d           = 1'b0;
        sclk_d           = cnt_d[0];
        mosi_d           = word_d[4'd15 - cnt_d[4:1]];
        dc_d             = 1'b1;
        sending_pixels_d = 1'b1;
        // Request one pixel ahead; the final slot has nothing left to fetch.
        pixel_index_d    = (pix_d == PixLast) ? 13'd0 : pix_d + 13'd1;
        sample_pixel_d   = (cnt_d == 7'd31) && (pix_d != PixLast);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk6p25m or posedge reset) begin
    if (reset) begin
      state_q        <= StGap;
      gap_q          <= '0;
      cnt_q          <= '0;
      pix_q          <= '0;
      word_q         <= '0;
      pixel_index    <= '0;
      frame_begin    <= 1'b0;
      sending_pixels <= 1'b0;
      sample_pixel   <= 1'b0;
      cs_n           <= 1'b1;
      sclk           <= 1'b1;
      mosi           <= 1'b0;
      dc             <= 1'b0;
    end else begin
      state_q        <= state_d;
      gap_q          <= gap_d;
      cnt_q          <= cnt_d;
      pix_q          <= pix_d;
      word_q         <= word_d;
      pixel_index    <= pixel_index_d;
      frame_begin    <= frame_begin_d;
      sending_pixels <= sending_pixels_d;
      sample_pixel   <= sample_pixel_d;
      cs_n           <= cs_n_d;
      sclk           <= sclk_d;
      mosi           <= mosi_d;
      dc             <= dc_d;
    end
  end

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Bench for oled_frame_streamer: a small 4x2 instance (gap 8) exercised with a
// fixed XOR pattern source, a mid-frame reset and random frame contents, plus a
// default-size instance whose preamble and first strobes are checked.
module tb_oled_frame_streamer;

  typedef struct packed {
    logic        fb;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        dc;
    logic        sp;
    logic        smp;
    logic [12:0] idx;
  } rec_t;

  typedef struct {
    int   off;
    rec_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset_big;
  logic        src_rand;
  logic [15:0] noise, pipe1, pipe2;
  logic [15:0] mem [0:7];

  logic [15:0] d1_pd, d2_pd;
  logic [12:0] d1_idx, d2_idx;
  logic        d1_fb, d1_sp, d1_smp, d1_cs, d1_sclk, d1_mosi, d1_dc;
  logic        d2_fb, d2_sp, d2_smp, d2_cs, d2_sclk, d2_mosi, d2_dc;

  oled_frame_streamer #(.WIDTH(4), .HEIGHT(2), .GAP_CYCLES(8)) u_dut (
    .clk6p25m      (clk),
    .reset         (reset),
    .pixel_data    (d1_pd),
    .pixel_index   (d1_idx),
    .frame_begin   (d1_fb),
    .sending_pixels(d1_sp),
    .sample_pixel  (d1_smp),
    .cs_n          (d1_cs),
    .sclk          (d1_sclk),
    .mosi          (d1_mosi),
    .dc            (d1_dc)
  );

  oled_frame_streamer u_dut_big (
    .clk6p25m      (clk),
    .reset         (reset_big),
    .pixel_data    (d2_pd),
    .pixel_index   (d2_idx),
    .frame_begin   (d2_fb),
    .sending_pixels(d2_sp),
    .sample_pixel  (d2_smp),
    .cs_n          (d2_cs),
    .sclk          (d2_sclk),
    .mosi          (d2_mosi),
    .dc            (d2_dc)
  );

  // Source: either index^A5A5 with two cycles of registered latency, or a random
  // frame buffer that only presents real data on sample cycles and noise otherwise.
  always @(posedge clk) begin
    pipe1 <= {3'b000, d1_idx} ^ 16'hA5A5;
    pipe2 <= pipe1;
  end
  always @(negedge clk) noise <= 16'($urandom);
  assign d1_pd = src_rand ? (d1_smp ? mem[d1_idx[2:0]] : noise) : pipe2;
  assign d2_pd = noise;

  int nchk = 0;
  int nerr = 0;

  rec_t       rec [0:399];
  logic [7:0]  cmd_q [$];
  logic [15:0] pix_q [$];
  logic [7:0]  exp_cmd [0:5];
  vec_t        vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rec_t snap(input bit big);
    rec_t r;
    if (big) begin
      r.fb = d2_fb; r.cs_n = d2_cs; r.sclk = d2_sclk; r.mosi = d2_mosi;
      r.dc = d2_dc; r.sp = d2_sp; r.smp = d2_smp; r.idx = d2_idx;
    end else begin
      r.fb = d1_fb; r.cs_n = d1_cs; r.sclk = d1_sclk; r.mosi = d1_mosi;
      r.dc = d1_dc; r.sp = d1_sp; r.smp = d1_smp; r.idx = d1_idx;
    end
    return r;
  endfunction

  function automatic rec_t mk(input bit fb, input bit cs, input bit sc, input bit mo,
                              input bit dcv, input bit sp, input bit smp, input int idx);
    rec_t r;
    r.fb = fb; r.cs_n = cs; r.sclk = sc; r.mosi = mo;
    r.dc = dcv; r.sp = sp; r.smp = smp; r.idx = 13'(idx);
    return r;
  endfunction

  task automatic add_vec(input int off, input rec_t e);
    vec_t v;
    v.off = off;
    v.exp = e;
    vecs.push_back(v);
  endtask

  // Edges counted from the call until frame_begin is seen; -1 if never.
  task automatic wait_fb(input int maxw, input bit big, output int edges);
    int i;
    edges = -1;
    i = 0;
    while (edges < 0 && i < maxw) begin
      @(posedge clk);
      #1;
      i++;
      if (snap(big).fb === 1'b1) edges = i;
    end
  endtask

  task automatic record(input int len, input bit big);
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      rec[i] = snap(big);
    end
  endtask

  // Rebuild bytes and words from the bits present on sclk-high cycles.
  task automatic decode(input int len);
    logic [7:0]  cb;
    logic [15:0] pw;
    int cn, pn;
    cmd_q.delete();
    pix_q.delete();
    cb = '0; pw = '0; cn = 0; pn = 0;
    for (int i = 0; i < len; i++) begin
      if (rec[i].cs_n === 1'b0 && rec[i].sclk === 1'b1) begin
        if (rec[i].dc === 1'b0) begin
          cb = {cb[6:0], rec[i].mosi};
          cn++;
          if (cn == 8) begin cmd_q.push_back(cb); cn = 0; end
        end else begin
          pw = {pw[14:0], rec[i].mosi};
          pn++;
          if (pn == 16) begin pix_q.push_back(pw); pn = 0; end
        end
      end
    end
  endtask

  // Whole-frame check of the 4x2 instance from rec[0..360] (rec[0] = frame_begin cycle).
  task automatic check_frame(input bit rnd);
    logic [15:0] expw;
    logic [12:0] exp_idx;
    bit exp_smp;
    int p, smp_n, bad_smp, bad_idx, bad_bus, bad_stab, bad_gap, bad_fb;
    decode(352);
    chk("cmd byte count", cmd_q.size(), 6);
    if (cmd_q.size() == 6)
      for (int i = 0; i < 6; i++) chk($sformatf("cmd byte %0d", i), cmd_q[i], exp_cmd[i]);
    chk("pixel word count", pix_q.size(), 8);
    if (pix_q.size() == 8)
      for (int i = 0; i < 8; i++) begin
        expw = rnd ? mem[i] : (16'(i) ^ 16'hA5A5);
        chk($sformatf("pixel word %0d", i), pix_q[i], expw);
      end
    smp_n = 0; bad_smp = 0; bad_idx = 0; bad_bus = 0; bad_stab = 0; bad_gap = 0; bad_fb = 0;
    for (int i = 0; i < 352; i++) begin
      p       = (i - 96) / 32;
      exp_smp = (i == 95) || (i >= 96 && (i - 96) % 32 == 31 && p < 7);
      exp_idx = (i < 96 || p == 7) ? 13'd0 : 13'(p + 1);
      if (rec[i].smp === 1'b1) smp_n++;
      if (rec[i].smp !== exp_smp) bad_smp++;
      if (rec[i].idx !== exp_idx) bad_idx++;
      if (rec[i].cs_n !== 1'b0 || rec[i].sclk !== 1'(i % 2) ||
          rec[i].dc !== 1'(i >= 96) || rec[i].sp !== 1'(i >= 96)) bad_bus++;
      if (i % 2 == 1 && rec[i].mosi !== rec[i-1].mosi) bad_stab++;
      if (i > 0 && rec[i].fb !== 1'b0) bad_fb++;
    end
    for (int i = 352; i < 360; i++)
      if (rec[i] !== mk(0, 1, 1, 0, 0, 0, 0, 0)) bad_gap++;
    chk("sample_pixel count", smp_n, 8);
    chk("sample_pixel placement", bad_smp, 0);
    chk("pixel_index sequence", bad_idx, 0);
    chk("cs_n/sclk/dc/sending pattern", bad_bus, 0);
    chk("mosi stable per bit", bad_stab, 0);
    chk("stray frame_begin", bad_fb, 0);
    chk("idle gap", bad_gap, 0);
    chk("next frame_begin", rec[360].fb, 1);
  endtask

  initial begin
    int e, smp_n;
    exp_cmd[0] = 8'h15; exp_cmd[1] = 8'h00; exp_cmd[2] = 8'h03;
    exp_cmd[3] = 8'h75; exp_cmd[4] = 8'h00; exp_cmd[5] = 8'h01;

    // Offset from frame_begin -> expected {fb,cs_n,sclk,mosi,dc,sp,smp,idx} (XOR source).
    add_vec(0,   mk(1, 0, 0, 0, 0, 0, 0, 0));
    add_vec(1,   mk(0, 0, 1, 0, 0, 0, 0, 0));
    add_vec(6,   mk(0, 0, 0, 1, 0, 0, 0, 0));
    add_vec(47,  mk(0, 0, 1, 1, 0, 0, 0, 0));
    add_vec(94,  mk(0, 0, 0, 1, 0, 0, 0, 0));
    add_vec(95,  mk(0, 0, 1, 1, 0, 0, 1, 0));
    add_vec(96,  mk(0, 0, 0, 1, 1, 1, 0, 1));
    add_vec(98,  mk(0, 0, 0, 0, 1, 1, 0, 1));
    add_vec(127, mk(0, 0, 1, 1, 1, 1, 1, 1));
    add_vec(128, mk(0, 0, 0, 1, 1, 1, 0, 2));
    add_vec(158, mk(0, 0, 0, 0, 1, 1, 0, 2));
    add_vec(320, mk(0, 0, 0, 1, 1, 1, 0, 0));
    add_vec(351, mk(0, 0, 1, 0, 1, 1, 0, 0));
    add_vec(352, mk(0, 1, 1, 0, 0, 0, 0, 0));
    add_vec(359, mk(0, 1, 1, 0, 0, 0, 0, 0));
    add_vec(360, mk(1, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
    src_rand  = 1'b0;
    reset     = 1'b1;
    reset_big = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", snap(0), mk(0, 1, 1, 0, 0, 0, 0, 0));

    // First frame with the XOR source.
    @(negedge clk);
    reset = 1'b0;
    wait_fb(50, 0, e);
    chk("first frame_begin edge", e, 8);
    record(361, 0);
    foreach (vecs[i]) chk($sformatf("vector off %0d", vecs[i].off), rec[vecs[i].off], vecs[i].exp);
    check_frame(0);

    // Reset during pixel 3, bit 15 phase 0.
    wait_fb(400, 0, e);
    chk("frame period", e, 360);
    repeat (192) begin
      @(posedge clk);
      #1;
    end
    chk("pixel 3 phase 0", {d1_sclk, d1_sp, d1_idx}, {1'b0, 1'b1, 13'd4});
    #2 reset = 1'b1;
    #1;
    chk("async reset mid-frame", snap(0), mk(0, 1, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    wait_fb(50, 0, e);
    chk("frame_begin after reset", e, 8);
    record(361, 0);
    check_frame(0);

    // Random frame contents, noise on pixel_data outside sample cycles.
    src_rand = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
      wait_fb(800, 0, e);
      chk("random frame period", e, 360);
      record(361, 0);
      check_frame(1);
    end

    // Default 96x64 geometry: preamble and first strobes.
    #1;
    chk("big reset state", snap(1), mk(0, 1, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset_big = 1'b0;
    wait_fb(1100, 1, e);
    chk("big first frame_begin edge", e, 1000);
    record(200, 1);
    decode(200);
    chk("big cmd byte count", cmd_q.size(), 6);
    if (cmd_q.size() == 6) begin
      chk("big cmd 0", cmd_q[0], 8'h15);
      chk("big cmd 2", cmd_q[2], 8'h5F);
      chk("big cmd 3", cmd_q[3], 8'h75);
      chk("big cmd 5", cmd_q[5], 8'h3F);
    end
    smp_n = 0;
    for (int i = 0; i < 200; i++) if (rec[i].smp === 1'b1) smp_n++;
    chk("big sample count in 200 cycles", smp_n, 4);
    chk("big sample at 95", rec[95].smp, 1);
    chk("big sample at 127", rec[127].smp, 1);
    chk("big index at 96", {rec[96].sp, rec[96].dc, rec[96].idx}, {1'b1, 1'b1, 13'd1});
    chk("big index at 128", rec[128].idx, 2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/oled_frame_streamer.md
Name: oled_frame_streamer

Overview:
- Consumer side of the pixel_index/pixel-colour interface that the game renderers answer.
- Each frame it walks pixel_index over the 96x64 panel in row-major order and samples the 16-bit RGB565 colour for each index.
- It sends a 6-byte address-window command preamble, then streams every pixel MSB-first over a 4-wire SPI link (cs_n, sclk, mosi, dc) to the PmodOLEDrgb on JA.
- It also drives the frame_begin, sending_pixels and sample_pixel status strobes.

Parameters:
- WIDTH, 96, pixels per row.
- HEIGHT, 64, rows per frame. WIDTH*HEIGHT must be ≤ 8192.
- GAP_CYCLES, 1000, idle cycles between frames (cs_n high). Must be ≥ 1.

Ports:
- clk6p25m  in  1  single clock for all logic (6.25 MHz).
- reset  in  1  asynchronous, active-high. Clears all state.
- pixel_data  in  16  RGB565 colour for the current pixel_index, valid on sample_pixel cycles.
- pixel_index  out  13  index being requested, y*WIDTH+x.
- frame_begin  out  1  1-cycle pulse on the first CMD cycle of each frame.
- sending_pixels  out  1  high throughout the PIXEL state.
- sample_pixel  out  1  1-cycle strobe; pixel_data is latched at the end of this cycle.
- cs_n  out  1  SPI chip select, active low.
- sclk  out  1  SPI clock, idle high.
- mosi  out  1  SPI data.
- dc  out  1  0 = command byte, 1 = pixel data.

Behaviour:
- All outputs are registered. States are GAP, CMD and PIXEL. Let N = WIDTH*HEIGHT.
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - state = GAP, gap counter = 0.
  - cs_n=1, sclk=1, mosi=0, dc=0, pixel_index=0.
  - frame_begin=0, sending_pixels=0, sample_pixel=0.
  - No partial frame is resumed after reset.
- GAP:
  - Counts cycles. On the GAP_CYCLES-th rising edge after entry (or after reset release) it moves to CMD.
  - On that same edge frame_begin goes high for exactly one cycle (cycle F).
- SPI bit timing, CMD and PIXEL states:
  - Each bit occupies 2 cycles: phase 0 sclk=0, phase 1 sclk=1.
  - mosi is stable across both phases, so it changes only on sclk falling and the panel samples on rising (mode 3).
  - cs_n=0 for all of CMD and PIXEL.
- CMD:
  - dc=0. Sends 0x15, 0x00, WIDTH-1, 0x75, 0x00, HEIGHT-1, MSB first: 48 bits, cycles F..F+95.
  - Command bit k is on cycles F+2k and F+2k+1.
  - pixel_index=0 throughout CMD.
  - sample_pixel=1 at cycle F+95; pixel 0 is latched into the shift register.
- PIXEL:
  - dc=1, sending_pixels=1.
  - Pixel p, bit j (j=0 is bit 15) is on cycles F+96+32p+2j and +1.
  - Lookahead: during the slot of pixel p, pixel_index = p+1, changing on the first cycle of the slot.
  - For p < N-1, sample_pixel=1 on the last slot cycle (F+96+32p+31), latching pixel p+1.
  - The source therefore sees each index stable for ≥ 31 cycles (≥ 95 for pixel 0) before the sample.
  - During the last slot (p = N-1): pixel_index=0 and no sample_pixel.
- Frame end:
  - At cycle F+96+32N the block returns to GAP with cs_n=1, sclk=1, mosi=0, dc=0, sending_pixels=0.
  - The next frame_begin is at F+96+32N+GAP_CYCLES.
- Widths and ordering:
  - pixel_index counter is 13 bits, wraps N-1 → 0, and never exceeds N-1.
  - Commands hold 8-bit values; WIDTH-1 and HEIGHT-1 are truncated to 8 bits.
  - Exactly N sample_pixel strobes per frame, counting the one in CMD.
- pixel_data is ignored except on sample_pixel cycles. Changes at other times have no effect.

Test Plan:
- Preamble: WIDTH=4, HEIGHT=2, GAP_CYCLES=8, reset released at edge 0 -> frame_begin=1 at edge 8 only; mosi bits sampled on sclk rising = 0x15,0x00,0x03,0x75,0x00,0x01 with dc=0, cs_n=0.
- Pixel stream: source returns pixel_index^16'hA5A5 with 2-cycle registered latency -> words shifted with dc=1 are 0xA5A5, 0xA5A4, … 0xA5A2 (8 pixels), MSB first, 32 cycles per pixel.
- Strobes: same config -> 8 sample_pixel pulses per frame, at F+95 then every 32 cycles; pixel_index=1..7 then 0 in the final slot; sending_pixels high exactly 256 cycles.
- Frame end: after the last bit of pixel 7 -> cs_n=1, sclk=1, mosi=0 on the next cycle; next frame_begin exactly 8 cycles later; pixel_index=0.
- Reset mid-frame: assert reset asynchronously during pixel 3 phase 0 -> within the same cycle cs_n=1, sclk=1, pixel_index=0, sending_pixels=0; after release, frame_begin after 8 cycles and the preamble restarts from 0x15.
- Default size: WIDTH=96, HEIGHT=64 -> 6144 sample_pixel per frame; the last preamble bytes are 0x5F and 0x3F; frame-to-frame period is 96+196608+1000 cycles.
